// File: rtl/buffer_if.sv
// Handshake-free access bus for the buffer: write enable, shared index, write data, read data.
interface buffer_if #(
    parameter int ADDR = 4,
    parameter int DATA = 8
);
    logic            we;
    logic [ADDR-1:0] index;
    logic [DATA-1:0] din;
    logic [DATA-1:0] dout;

    modport master (
        output we,
        output index,
        output din,
        input  dout
    );

    modport slave (
        input  we,
        input  index,
        input  din,
        output dout
    );
endinterface

// File: rtl/buffer.sv
// Single-port register-file scratch buffer, synchronous write and registered read on one index.
// Define BUFFER_WRITE_FIRST_EN to forward din to dout on a write edge (default is read-first).
module buffer #(
    parameter int ADDR = 4,
    parameter int DATA = 8
) (
    input  logic      clk,
    input  logic      rst,
    buffer_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR;

    logic [DATA-1:0] mem_q [DEPTH];
    logic [DATA-1:0] mem_d [DEPTH];
    logic [DATA-1:0] dout_q;
    logic [DATA-1:0] dout_d;

    always_comb begin
        mem_d  = mem_q;
        dout_d = mem_q[bus.index];
        if (bus.we) begin
            mem_d[bus.index] = bus.din;
`ifdef BUFFER_WRITE_FIRST_EN
            dout_d = bus.din;
`else
            dout_d = mem_q[bus.index];
`endif
        end
    end

    // Reset wins over any write presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout_q <= '0;
        end else begin
            mem_q  <= mem_d;
            dout_q <= dout_d;
        end
    end

    assign bus.dout = dout_q;
endmodule

// File: tb/tb_buffer.sv
// Bench for buffer: directed vector table, a full-depth sweep, then random traffic vs. a model.
module tb_buffer;
    localparam int ADDR  = 4;
    localparam int DATA  = 8;
    localparam int DEPTH = 1 << ADDR;
`ifdef BUFFER_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    typedef struct {
        logic            r;
        logic            w;
        logic [ADDR-1:0] i;
        logic [DATA-1:0] d;
        logic [DATA-1:0] exp_rf;
        logic [DATA-1:0] exp_wf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [DATA-1:0] m_mem [DEPTH];
    logic [DATA-1:0] m_dout;
    vec_t            vecs[$];

    buffer_if #(.ADDR(ADDR), .DATA(DATA)) bif ();

    buffer #(.ADDR(ADDR), .DATA(DATA)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic w, input int i, input int d,
                       input int exp_rf, input int exp_wf);
        vec_t v;
        v.r = r; v.w = w; v.i = ADDR'(i); v.d = DATA'(d);
        v.exp_rf = DATA'(exp_rf); v.exp_wf = DATA'(exp_wf);
        vecs.push_back(v);
    endtask

    // Drive one access, let one edge pass, advance the model, settle 1 time unit.
    task automatic step(input logic r, input logic w, input logic [ADDR-1:0] i,
                        input logic [DATA-1:0] d);
        logic [DATA-1:0] old;
        rst = r; bif.we = w; bif.index = i; bif.din = d;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
            m_dout = '0;
        end else begin
            old = m_mem[i];
            if (w) m_mem[i] = d;
            m_dout = (w && WF) ? d : old;
        end
        #1;
    endtask

    task automatic check(input string name, input logic [DATA-1:0] got,
                         input logic [DATA-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: dout=%02h expected %02h", name, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; bif.we = 1'b0; bif.index = '0; bif.din = '0;

        // reset clear and sweep
        add(1, 0, 0, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < DEPTH; k++) add(0, 0, k, 8'h00, 8'h00, 8'h00);
        // write / read back
        add(0, 1, 2,  8'hAA, 8'h00, 8'hAA);
        add(0, 1, 5,  8'h55, 8'h00, 8'h55);
        add(0, 1, 10, 8'hF0, 8'h00, 8'hF0);
        add(0, 0, 2,  8'h00, 8'hAA, 8'hAA);
        add(0, 0, 5,  8'h00, 8'h55, 8'h55);
        add(0, 0, 10, 8'h00, 8'hF0, 8'hF0);
        add(0, 0, 3,  8'h00, 8'h00, 8'h00);
        // overwrite and index boundaries
        add(0, 1, 15, 8'h3C, 8'h00, 8'h3C);
        add(0, 1, 15, 8'hC3, 8'h3C, 8'hC3);
        add(0, 1, 0,  8'h11, 8'h00, 8'h11);
        add(0, 0, 15, 8'h00, 8'hC3, 8'hC3);
        add(0, 0, 0,  8'h00, 8'h11, 8'h11);
        add(0, 0, 14, 8'h00, 8'h00, 8'h00);
        // read-during-write
        add(0, 1, 7,  8'h12, 8'h00, 8'h12);
        add(0, 1, 7,  8'h34, 8'h12, 8'h34);
        add(0, 0, 7,  8'h00, 8'h34, 8'h34);
        // reset mid-operation suppresses the write and clears everything
        add(0, 1, 4,  8'h99, 8'h00, 8'h99);
        add(0, 0, 4,  8'h00, 8'h99, 8'h99);
        add(1, 1, 4,  8'h77, 8'h00, 8'h00);
        add(0, 0, 4,  8'h00, 8'h00, 8'h00);
        add(0, 0, 2,  8'h00, 8'h00, 8'h00);
        add(0, 0, 15, 8'h00, 8'h00, 8'h00);
        // back-to-back alternation
        add(0, 1, 9,  8'h01, 8'h00, 8'h01);
        add(0, 0, 9,  8'h00, 8'h01, 8'h01);
        add(0, 1, 9,  8'h02, 8'h01, 8'h02);
        add(0, 0, 9,  8'h00, 8'h02, 8'h02);
        add(0, 1, 9,  8'h03, 8'h02, 8'h03);
        add(0, 0, 9,  8'h00, 8'h03, 8'h03);

        foreach (vecs[n]) begin
            step(vecs[n].r, vecs[n].w, vecs[n].i, vecs[n].d);
            check($sformatf("vec%0d", n), bif.dout, WF ? vecs[n].exp_wf : vecs[n].exp_rf);
        end

        // full-depth fill then read back, values derived from the index
        for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, ADDR'(k), DATA'(k * 13 + 7));
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b0, 1'b0, ADDR'(k), 8'h00);
            check($sformatf("sweep%0d", k), bif.dout, DATA'(k * 13 + 7));
        end
        // dout must hold between edges
        @(negedge clk);
        check("hold", bif.dout, DATA'((DEPTH - 1) * 13 + 7));

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
                 ADDR'($urandom), DATA'($urandom));
            check($sformatf("rand%0d", n), bif.dout, m_dout);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
